kim1_display_keypad: RTL and testbench

Downstream consumer of the RRIOT's port A/B outputs on a KIM-1-style board. It decodes the port B digit/row select and the port A segment drive into a persistent six-digit 7-segment image. It also scans a debounced 21-key matrix back onto the port A input bus. It replaces the discrete 74145 decoder, LED multiplex and keypad matrix, giving the FPGA a static display image and a clean PAI.

---
 rtl/kim1_pkg.sv | 19 +
 rtl/kim1_display_keypad_key_debounce.sv | 52 +++++
 rtl/kim1_display_keypad.sv | 129 ++++++++++++
 tb/tb_kim1_display_keypad.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/kim1_pkg.sv
// ============================================================================
// Module   : kim1_pkg
// Purpose  : Shared constants and types for the KIM-1 display/keypad block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package kim1_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam int         ROW_KEYS   = 7;
  localparam logic [3:0] SEL_DIGIT0 = 4'd4;
  localparam logic [3:0] SEL_NONE   = 4'hF;

  typedef logic [6:0] seg_t;

endpackage

`default_nettype wire

// File: rtl/kim1_display_keypad_key_debounce.sv
// ============================================================================
// Module   : key_debounce
// Purpose  : 2-FF synchronizer plus shared-counter debouncer for a key vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int          WIDTH    = 21,
  parameter logic [15:0] DEBOUNCE = 16'd20000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_keys
);

  localparam logic [15:0] c_last = DEBOUNCE - 16'd1;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_keys;
  logic [15:0]      r_cnt;

  // One counter covers the whole vector: any change anywhere restarts the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_keys  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == c_last) begin
        r_keys <= r_cand;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_keys = r_keys;

endmodule

`default_nettype wire

// File: rtl/kim1_display_keypad.sv
// ============================================================================
// Module   : kim1_display_keypad
// Purpose  : Decodes RRIOT port A/B into a persistent 6-digit image and scans
//            a debounced 21-key matrix back onto PAI.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kim1_display_keypad
  import kim1_pkg::*;
#(
  parameter int          SETTLE   = 4,
  parameter logic [15:0] PERSIST  = 16'd50000,
  parameter logic [15:0] DEBOUNCE = 16'd20000
) (
  input  logic        phi2,
  input  logic        rst_n,
  input  logic [7:0]  PAO,
  input  logic [7:0]  DDRA,
  input  logic [7:0]  PBO,
  input  logic [7:0]  DDRB,
  output logic [7:0]  PAI,
  input  logic [20:0] key_raw,
  input  logic        tty_in,
  output logic [41:0] seg,
  output logic [5:0]  digit_valid,
  output logic        key_any
);

  localparam logic [2:0] c_settle    = 3'(SETTLE);
  localparam logic [2:0] c_settle_m1 = 3'(SETTLE - 1);

  logic [3:0]  w_sel;
  seg_t        w_segd;
  logic [10:0] w_pair;
  logic        w_stable_hit;
  logic [20:0] w_keys;
  logic [6:0]  w_row_n;
  logic        w_unused;

  logic [10:0] r_prev;
  logic [2:0]  r_stable;
  logic        r_key_any;

  assign w_sel  = (DDRB[4:1] == 4'hF) ? PBO[4:1] : SEL_NONE;
  assign w_segd = PAO[6:0] & DDRA[6:0];
  assign w_pair = {w_sel, w_segd};

  assign w_unused = ^{PAO[7], DDRA[7], PBO[7:5], PBO[0], DDRB[7:5], DDRB[0]};

  // Counter saturates so a held pair captures once, not every cycle.
  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_stable <= '0;
    end else if (w_pair != r_prev) begin
      r_prev   <= w_pair;
      r_stable <= '0;
    end else if (r_stable != c_settle) begin
      r_stable <= r_stable + 3'd1;
    end
  end

  assign w_stable_hit = (w_pair == r_prev) && (r_stable == c_settle_m1);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic        w_cap;
    seg_t        r_seg;
    logic        r_valid;
    logic [15:0] r_persist;

    assign w_cap = w_stable_hit && (w_sel == SEL_DIGIT0 + 4'(i));

    // Capture takes priority over an expiry landing on the same edge.
    always_ff @(posedge phi2) begin
      if (!rst_n) begin
        r_seg     <= '0;
        r_valid   <= 1'b0;
        r_persist <= '0;
      end else if (w_cap) begin
        r_seg     <= w_segd;
        r_valid   <= 1'b1;
        r_persist <= PERSIST;
      end else if (r_persist != 16'd0) begin
        r_persist <= r_persist - 16'd1;
        if (r_persist == 16'd1) begin
          r_seg   <= '0;
          r_valid <= 1'b0;
        end
      end
    end

    assign seg[ROW_KEYS*i +: ROW_KEYS] = r_seg;
    assign digit_valid[i]              = r_valid;
  end

  key_debounce #(
    .WIDTH    (21),
    .DEBOUNCE (DEBOUNCE)
  ) u_key_debounce (
    .clk    (phi2),
    .rst_n  (rst_n),
    .i_raw  (key_raw),
    .o_keys (w_keys)
  );

  // Row read is combinational so the CPU sees its row in the same cycle.
  always_comb begin
    w_row_n = 7'h7F;
    case (w_sel)
      4'd0:    w_row_n = ~w_keys[6:0];
      4'd1:    w_row_n = ~w_keys[13:7];
      4'd2:    w_row_n = ~w_keys[20:14];
      default: w_row_n = 7'h7F;
    endcase
  end

  assign PAI = {tty_in, w_row_n};

  always_ff @(posedge phi2) begin
    if (!rst_n) r_key_any <= 1'b0;
    else        r_key_any <= |w_keys;
  end

  assign key_any = r_key_any;

endmodule

`default_nettype wire

// File: tb/tb_kim1_display_keypad.sv
// ============================================================================
// Module   : tb_kim1_display_keypad
// Purpose  : Directed self-checking bench for kim1_display_keypad.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kim1_display_keypad;

  logic        phi2 = 1'b0;
  logic        rst_n;
  logic [7:0]  PAO, DDRA, PBO, DDRB;
  logic [7:0]  PAI;
  logic [20:0] key_raw;
  logic        tty_in;
  logic [41:0] seg;
  logic [5:0]  digit_valid;
  logic        key_any;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 phi2 = ~phi2;

  kim1_display_keypad #(
    .SETTLE   (4),
    .PERSIST  (16'd100),
    .DEBOUNCE (16'd16)
  ) dut (
    .phi2        (phi2),
    .rst_n       (rst_n),
    .PAO         (PAO),
    .DDRA        (DDRA),
    .PBO         (PBO),
    .DDRB        (DDRB),
    .PAI         (PAI),
    .key_raw     (key_raw),
    .tty_in      (tty_in),
    .seg         (seg),
    .digit_valid (digit_valid),
    .key_any     (key_any)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each tick advances one rising edge and leaves us 1 ns past it.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge phi2);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; tty_in = 1'b1; key_raw = '0;
    PAO = 8'h00; DDRA = 8'h00; PBO = 8'h00; DDRB = 8'h00;
    ticks(3);
    check("rst_seg", 64'(seg), 64'h0);
    check("rst_valid", 64'(digit_valid), 64'h0);
    check("rst_pai", 64'(PAI), 64'hFF);
    check("rst_key_any", 64'(key_any), 64'h0);
    rst_n = 1'b1;
    ticks(2);

    // Digit 0 capture: first sampled at edge k, captured at edge k+4.
    DDRB = 8'h1E; DDRA = 8'h7F; PBO = 8'h08; PAO = 8'h06;
    ticks(4);
    check("cap0_early_valid", 64'(digit_valid), 64'h0);
    ticks(1);
    check("cap0_seg", 64'(seg[6:0]), 64'h06);
    check("cap0_valid", 64'(digit_valid), 64'h01);

    PBO = 8'h12; PAO = 8'h5B;
    ticks(4);
    check("cap5_early_valid", 64'(digit_valid), 64'h01);
    ticks(1);
    check("cap5_seg", 64'(seg[41:35]), 64'h5B);
    check("cap5_valid", 64'(digit_valid), 64'h21);

    // Persistence: fresh capture of digit 0, then deselect.
    PBO = 8'h08; PAO = 8'h06;
    ticks(5);
    check("pers_cap", 64'(digit_valid[0]), 64'h1);
    PBO = 8'h1E;
    ticks(99);
    check("pers_99_valid", 64'(digit_valid[0]), 64'h1);
    check("pers_99_seg", 64'(seg[6:0]), 64'h06);
    ticks(1);
    check("pers_100_valid", 64'(digit_valid[0]), 64'h0);
    check("pers_100_seg", 64'(seg[6:0]), 64'h0);

    // Recapture at c+50 extends expiry to c+150.
    PBO = 8'h08;
    ticks(5);
    check("ext_cap", 64'(digit_valid[0]), 64'h1);
    PBO = 8'h1E;
    ticks(45);
    PBO = 8'h08;
    ticks(5);
    PBO = 8'h1E;
    ticks(50);
    check("ext_100_valid", 64'(digit_valid[0]), 64'h1);
    ticks(49);
    check("ext_149_valid", 64'(digit_valid[0]), 64'h1);
    ticks(1);
    check("ext_150_valid", 64'(digit_valid[0]), 64'h0);

    // Keypad: key 8 is row 1, column 1.
    PBO = 8'h02;
    key_raw[8] = 1'b1;
    ticks(18);
    check("key_edge17_pai", 64'(PAI), 64'hFF);
    ticks(1);
    check("key_edge18_pai", 64'(PAI), 64'hFD);
    ticks(1);
    check("key_any", 64'(key_any), 64'h1);
    PBO = 8'h00; #1;
    check("key_row0_pai", 64'(PAI), 64'hFF);
    PBO = 8'h04; #1;
    check("key_row2_pai", 64'(PAI), 64'hFF);
    PBO = 8'h02; tty_in = 1'b0; #1;
    check("key_tty_pai", 64'(PAI), 64'h7D);
    tty_in = 1'b1;

    // Bounce on key 3 (row 0) never survives a 16-cycle window.
    PBO = 8'h00;
    for (int t = 0; t < 20; t++) begin
      key_raw[3] = ~key_raw[3];
      ticks(10);
      check("bounce_row0_pai", 64'(PAI), 64'hFF);
    end
    ticks(25);
    check("bounce_settled_row0", 64'(PAI), 64'hFF);
    PBO = 8'h02; #1;
    check("bounce_row1_pai", 64'(PAI), 64'hFD);

    // Incomplete port B direction means nothing is selected.
    DDRB = 8'h0E; #1;
    check("dir_pai", 64'(PAI), 64'hFF);
    PBO = 8'h08; PAO = 8'h06; DDRA = 8'h7F;
    ticks(10);
    check("dir_no_capture", 64'(digit_valid), 64'h0);
    check("dir_pai_sel4", 64'(PAI), 64'hFF);

    // Reset mid-operation with a lit digit and a pending key.
    DDRB = 8'h1E;
    ticks(5);
    check("mid_cap", 64'(digit_valid), 64'h01);
    key_raw[5] = 1'b1;
    ticks(5);
    rst_n = 1'b0; PBO = 8'h02;
    ticks(1);
    check("mid_rst_seg", 64'(seg), 64'h0);
    check("mid_rst_valid", 64'(digit_valid), 64'h0);
    check("mid_rst_key_any", 64'(key_any), 64'h0);
    check("mid_rst_pai", 64'(PAI), 64'hFF);
    rst_n = 1'b1;
    ticks(10);
    check("post_rst_pai", 64'(PAI), 64'hFF);
    check("post_rst_valid", 64'(digit_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
